// File: rtl/fetch_sequencer_pkg.sv
// Shared run-control definitions: FSM state codes, PC source select codes and the HALT encoding.
// The PC register, hazard unit and debug unit import the same package.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } run_state_e;

  localparam logic [1:0] SEL_INC  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JMP  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam int          PC_WIDTH  = 10;

  // States in which every pipeline register advances.
  function automatic logic stage_active(run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch run-control FSM: picks the PC source, gates the pipeline and drains it on a fetched HALT.
// Outputs are combinational from state and flags so they settle before the PC's negedge update.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic [31:0]          instruction,
  input  logic                 branch_taken,
  input  logic                 jump_taken,
  input  logic                 hazard_stall,
  output logic [1:0]           pc_sel,
  output logic                 pc_en,
  output logic                 pipe_en,
  output logic                 if_id_flush,
  output logic                 halted,
  output logic [2:0]           run_state,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int DCW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  run_state_e           state_q, state_d;
  logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                 halt_fetch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      drain_cnt_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign pipe_en    = stage_active(state_q);
  // A redirect in the same cycle squashes the HALT word, so it must not stop fetch.
  assign halt_fetch = (instruction == HALT_WORD) && pipe_en && !branch_taken && !jump_taken;

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    cycle_count_d = cycle_count_q;
    if (pipe_en && (cycle_count_q != '1)) cycle_count_d = cycle_count_q + 1'b1;
    unique case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (run_req)       state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        if (halt_fetch) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DCW'(PIPE_DEPTH - 1);
        end else if (state_q == ST_STEP || halt_req) begin
          state_d = ST_PAUSE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) state_d = ST_HALTED;
        else                   drain_cnt_d = drain_cnt_q - 1'b1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_sel      = SEL_HOLD;
    pc_en       = 1'b0;
    if_id_flush = 1'b0;
    if (state_q == ST_RUN || state_q == ST_STEP) begin
      if (branch_taken) begin
        pc_sel      = SEL_BR;
        pc_en       = 1'b1;
        if_id_flush = 1'b1;
      end else if (jump_taken) begin
        pc_sel      = SEL_JMP;
        pc_en       = 1'b1;
        if_id_flush = 1'b1;
      end else if (!hazard_stall) begin
        pc_sel = SEL_INC;
        pc_en  = 1'b1;
      end
    end else if (state_q == ST_DRAIN) begin
      if_id_flush = 1'b1;
    end
  end

  assign halted      = (state_q == ST_HALTED);
  assign run_state   = state_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second instance with a 3-bit counter exercises saturation.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        branch_taken = 1'b0, jump_taken = 1'b0, hazard_stall = 1'b0;

  logic [1:0]  pc_sel;
  logic        pc_en, pipe_en, if_id_flush, halted;
  logic [2:0]  run_state;
  logic [31:0] cycle_count;

  logic [1:0]  s_pc_sel;
  logic        s_pc_en, s_pipe_en, s_if_id_flush, s_halted;
  logic [2:0]  s_run_state;
  logic [2:0]  s_cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .instruction(instruction), .branch_taken(branch_taken), .jump_taken(jump_taken),
    .hazard_stall(hazard_stall), .pc_sel(pc_sel), .pc_en(pc_en), .pipe_en(pipe_en),
    .if_id_flush(if_id_flush), .halted(halted), .run_state(run_state), .cycle_count(cycle_count)
  );

  fetch_sequencer #(.PIPE_DEPTH(4), .CNT_WIDTH(3)) dut_s (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .instruction(instruction), .branch_taken(branch_taken), .jump_taken(jump_taken),
    .hazard_stall(hazard_stall), .pc_sel(s_pc_sel), .pc_en(s_pc_en), .pipe_en(s_pipe_en),
    .if_id_flush(s_if_id_flush), .halted(s_halted), .run_state(s_run_state),
    .cycle_count(s_cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Check the combinational output set in one go.
  task automatic chk_out(input string tag, input logic [2:0] st, input logic pe,
                         input logic [1:0] sel, input logic pce, input logic fl, input logic hl);
    chk({tag, ".state"}, 32'(run_state), 32'(st));
    chk({tag, ".pipe_en"}, 32'(pipe_en), 32'(pe));
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(sel));
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(pce));
    chk({tag, ".flush"}, 32'(if_id_flush), 32'(fl));
    chk({tag, ".halted"}, 32'(halted), 32'(hl));
  endtask

  initial begin
    // 1. reset and idle
    repeat (2) @(posedge clk);
    #2;
    chk_out("rst", 3'd0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("rst.count", cycle_count, 32'd0);
    reset = 1'b1;
    repeat (5) nxt();
    #1;
    chk_out("idle", 3'd0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("idle.count", cycle_count, 32'd0);

    // 2. free run, sequential fetch
    run_req = 1'b1;
    nxt();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_out("run", 3'd1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
      nxt();
    end
    chk("run.count", cycle_count, 32'd10);
    chk("run.sat3", 32'(s_cycle_count), 32'd7);

    // 3. redirect priority
    hazard_stall = 1'b1; branch_taken = 1'b1;
    #1;
    chk_out("br_stall", 3'd1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    nxt();
    branch_taken = 1'b0;
    #1;
    chk_out("stall", 3'd1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    hazard_stall = 1'b0; jump_taken = 1'b1;
    #1;
    chk_out("jump", 3'd1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    nxt();
    jump_taken = 1'b0; branch_taken = 1'b1; instruction = 32'hFFFF_FFFF;
    nxt();
    branch_taken = 1'b0; instruction = 32'h0;
    #1;
    chk("squashed_halt.state", 32'(run_state), 32'd1);
    chk("run.count13", cycle_count, 32'd13);

    // 4. step_req ignored in RUN; halt_req pauses; single step from PAUSE
    step_req = 1'b1;
    nxt();
    step_req = 1'b0;
    #1;
    chk("step_in_run.state", 32'(run_state), 32'd1);
    run_req = 1'b0; halt_req = 1'b1;
    #1;
    chk("halt_req.pipe_en", 32'(pipe_en), 32'd1);
    nxt();
    halt_req = 1'b0;
    #1;
    chk_out("pause", 3'd3, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("pause.count", cycle_count, 32'd15);
    nxt();
    step_req = 1'b1;
    nxt();
    step_req = 1'b0;
    #1;
    chk_out("step", 3'd2, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    nxt();
    chk_out("after_step", 3'd3, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("after_step.count", cycle_count, 32'd16);
    run_req = 1'b1; step_req = 1'b1;
    nxt();
    step_req = 1'b0;
    #1;
    chk("run_wins.state", 32'(run_state), 32'd1);

    // 5. HALT fetch -> drain -> halted
    instruction = 32'hFFFF_FFFF;
    nxt();
    instruction = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out("drain", 3'd4, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
      nxt();
    end
    chk_out("halted", 3'd5, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
    chk("halted.count", cycle_count, 32'd21);
    run_req = 1'b0;
    nxt();
    run_req = 1'b1;
    nxt();
    run_req = 1'b0; step_req = 1'b1;
    nxt();
    step_req = 1'b0;
    #1;
    chk("halted_sticky.state", 32'(run_state), 32'd5);
    chk("halted_sticky.count", cycle_count, 32'd21);

    // 6. reset in the middle of DRAIN
    reset = 1'b0;
    #1;
    reset = 1'b1;
    run_req = 1'b1;
    nxt();
    instruction = 32'hFFFF_FFFF;
    nxt();
    instruction = 32'h0;
    #1;
    chk("drain1.state", 32'(run_state), 32'd4);
    nxt();
    chk("drain2.state", 32'(run_state), 32'd4);
    reset = 1'b0;
    #1;
    chk_out("abort", 3'd0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("abort.count", cycle_count, 32'd0);
    reset = 1'b1;
    nxt();
    #1;
    chk_out("resume", 3'd1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    nxt();
    chk("resume.count", cycle_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, required finish within 20000");
    $fatal(1, "timeout");
  end

endmodule
